// File: rtl/int_sched.sv
// Priority interrupt scheduler: picks the highest eligible source, requests the CPU with a
// code/ack handshake, and tracks in-service sources until software issues EOI over Wishbone.
module int_sched #(
  parameter int GAP_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] IRQ_IN,
  output logic       INT_REQo,
  output logic [2:0] INT_CODEo,
  input  logic       INT_ACKi,
  input  logic [2:0] WB_ADRi,
  input  logic [7:0] WB_DATi,
  output logic [7:0] WB_DATo,
  input  logic       WB_WEi,
  input  logic       WB_CYCi,
  input  logic       WB_STBi,
  output logic       WB_ACKo,
  output logic [1:0] o_dbg_state
);

  // CPU handshake: INT_REQo is held with a frozen INT_CODEo until INT_ACKi is seen
  // (or EN drops); INT_ACKi is only meaningful while INT_REQo=1.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYC);

  state_t     r_state;
  logic       r_en;
  logic       r_nest;
  logic [7:0] r_mask;
  logic [7:0] r_isr;
  logic       r_req;
  logic [2:0] r_code;
  logic [3:0] r_gap_cnt;

  logic       w_wr;
  logic       w_eoi;
  logic       w_ack_take;
  logic [2:0] w_isr_top;
  logic [7:0] w_above;
  logic [7:0] w_raw;
  logic [7:0] w_elig;
  logic [2:0] w_sel;
  logic [7:0] w_eoi_clr;
  logic [7:0] w_isr_set;

  function automatic logic [2:0] f_top(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign w_wr       = WB_CYCi & WB_STBi & WB_WEi;
  assign w_eoi      = w_wr & (WB_ADRi == 3'd3);
  assign w_ack_take = (r_state == S_REQ) & INT_ACKi;
  assign w_isr_top  = f_top(r_isr);
  assign w_raw      = IRQ_IN & r_mask & ~r_isr;
  assign w_sel      = f_top(w_elig);

  always_comb begin
    w_above = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_above[i] = (3'(i) > w_isr_top);
    end
  end

  // With something in service, only nested mode lets strictly higher sources through.
  always_comb begin
    w_elig = w_raw;
    if (r_isr != 8'h00) w_elig = r_nest ? (w_raw & w_above) : 8'h00;
  end

  always_comb begin
    w_eoi_clr = 8'h00;
    if (w_eoi) begin
      if (WB_DATi[7]) w_eoi_clr = 8'b1 << WB_DATi[2:0];
      else if (r_isr != 8'h00) w_eoi_clr = 8'b1 << w_isr_top;
    end
  end

  // The set term is OR-ed after the clear so an acknowledge beats an EOI of the same bit.
  assign w_isr_set = w_ack_take ? (8'b1 << r_code) : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_en      <= 1'b0;
      r_nest    <= 1'b0;
      r_mask    <= 8'h00;
      r_isr     <= 8'h00;
      r_req     <= 1'b0;
      r_code    <= 3'd0;
      r_gap_cnt <= 4'd0;
    end else begin
      if (w_wr && WB_ADRi == 3'd0) begin
        r_en   <= WB_DATi[7];
        r_nest <= WB_DATi[0];
      end
      if (w_wr && WB_ADRi == 3'd1) r_mask <= WB_DATi;
      r_isr <= (r_isr & ~w_eoi_clr) | w_isr_set;

      case (r_state)
        S_IDLE: begin
          if (r_en && (w_elig != 8'h00)) begin
            r_code  <= w_sel;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (INT_ACKi || !r_en) begin
            r_req     <= 1'b0;
            r_gap_cnt <= GAP_LOAD;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap_cnt <= 4'd1) begin
            r_gap_cnt <= 4'd0;
            r_state   <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    WB_DATo = 8'h00;
    case (WB_ADRi)
      3'd0:    WB_DATo = {r_en, 6'b000000, r_nest};
      3'd1:    WB_DATo = r_mask;
      3'd2:    WB_DATo = IRQ_IN & r_mask;
      3'd3:    WB_DATo = r_isr;
      3'd4:    WB_DATo = {r_req, 4'b0000, r_code};
      default: WB_DATo = 8'h00;
    endcase
  end

  assign WB_ACKo     = WB_CYCi & WB_STBi;
  assign INT_REQo    = r_req;
  assign INT_CODEo   = r_code;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_int_sched.sv
// Directed bench for int_sched: drivers push expected request codes and read data into
// queues; a negedge monitor pops and compares whenever the DUT presents a request or a read.
module tb_int_sched;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] IRQ_IN;
  logic       INT_REQo;
  logic [2:0] INT_CODEo;
  logic       INT_ACKi;
  logic [2:0] WB_ADRi;
  logic [7:0] WB_DATi;
  logic [7:0] WB_DATo;
  logic       WB_WEi;
  logic       WB_CYCi;
  logic       WB_STBi;
  logic       WB_ACKo;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [2:0]  exp_q[$];
  logic [10:0] exp_rd_q[$];
  logic [10:0] rd_e;
  logic [2:0]  code_e;
  logic        prev_req = 1'b0;
  int          low_cnt;

  int_sched #(.GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .IRQ_IN(IRQ_IN), .INT_REQo(INT_REQo), .INT_CODEo(INT_CODEo),
    .INT_ACKi(INT_ACKi), .WB_ADRi(WB_ADRi), .WB_DATi(WB_DATi), .WB_DATo(WB_DATo),
    .WB_WEi(WB_WEi), .WB_CYCi(WB_CYCi), .WB_STBi(WB_STBi), .WB_ACKo(WB_ACKo),
    .o_dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (WB_CYCi && WB_STBi && !WB_WEi) begin
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected adr=%0d got=%h", WB_ADRi, WB_DATo);
      end else begin
        rd_e = exp_rd_q.pop_front();
        if (WB_DATo !== rd_e[7:0] || WB_ACKo !== 1'b1 || WB_ADRi !== rd_e[10:8]) begin
          errors++;
          $display("FAIL rd_adr%0d got=%h ack=%b exp=%h", rd_e[10:8], WB_DATo, WB_ACKo, rd_e[7:0]);
        end
      end
    end
    if (INT_REQo && !prev_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req got_code=%0d exp=no request", INT_CODEo);
      end else begin
        code_e = exp_q.pop_front();
        if (INT_CODEo !== code_e) begin
          errors++;
          $display("FAIL req_code got=%0d exp=%0d", INT_CODEo, code_e);
        end
      end
    end
    prev_req = INT_REQo;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wb_set_write(input logic [2:0] adr, input logic [7:0] dat);
    WB_ADRi = adr; WB_DATi = dat; WB_WEi = 1'b1; WB_CYCi = 1'b1; WB_STBi = 1'b1;
  endtask

  task automatic wb_clear();
    WB_WEi = 1'b0; WB_CYCi = 1'b0; WB_STBi = 1'b0; WB_DATi = 8'h00;
  endtask

  task automatic wb_write(input logic [2:0] adr, input logic [7:0] dat);
    wb_set_write(adr, dat);
    tick();
    wb_clear();
  endtask

  task automatic wb_read(input logic [2:0] adr, input logic [7:0] exp);
    exp_rd_q.push_back({adr, exp});
    WB_ADRi = adr; WB_WEi = 1'b0; WB_CYCi = 1'b1; WB_STBi = 1'b1;
    tick();
    wb_clear();
  endtask

  task automatic ack();
    INT_ACKi = 1'b1;
    tick();
    INT_ACKi = 1'b0;
  endtask

  task automatic wait_req(input int max_cyc);
    int n;
    n = 0;
    while (!INT_REQo && n < max_cyc) begin
      tick();
      n++;
    end
    checks++;
    if (!INT_REQo) begin
      errors++;
      $display("FAIL wait_req got=no request after %0d cycles exp=request", max_cyc);
    end
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1; IRQ_IN = 8'h00; INT_ACKi = 1'b0;
    WB_ADRi = 3'd0; WB_DATi = 8'h00; WB_WEi = 1'b0; WB_CYCi = 1'b0; WB_STBi = 1'b0;
    idle(3);
    rst = 1'b0;
    chk("rst_req", {7'b0, INT_REQo}, 8'h00);
    wb_read(3'd0, 8'h00);
    wb_read(3'd1, 8'h00);
    wb_read(3'd3, 8'h00);
    wb_read(3'd4, 8'h00);

    // Nested basic request, ack, lower source blocked
    wb_write(3'd1, 8'hFF);
    wb_write(3'd0, 8'h81);
    exp_q.push_back(3'd2);
    IRQ_IN = 8'h06;
    tick();
    chk("req_latency", {7'b0, INT_REQo}, 8'h01);
    wb_read(3'd4, 8'h82);
    ack();
    chk("req_drop_after_ack", {7'b0, INT_REQo}, 8'h00);
    wb_read(3'd3, 8'h04);
    idle(12);
    wb_read(3'd2, 8'h06);

    // EOI highest, re-request, indexed EOI
    exp_q.push_back(3'd2);
    wb_write(3'd3, 8'h00);
    wb_read(3'd3, 8'h00);
    wait_req(20);
    ack();
    IRQ_IN = 8'h00;
    wb_write(3'd3, 8'h82);
    wb_read(3'd3, 8'h00);

    // Non-nested mode blocks everything while in service
    wb_write(3'd0, 8'h80);
    exp_q.push_back(3'd0);
    IRQ_IN = 8'h01;
    wait_req(20);
    ack();
    IRQ_IN = 8'h80;
    wb_read(3'd3, 8'h01);
    idle(12);
    wb_read(3'd2, 8'h80);
    exp_q.push_back(3'd7);
    wb_write(3'd3, 8'h00);
    wait_req(20);
    ack();
    IRQ_IN = 8'h00;
    wb_read(3'd3, 8'h80);
    wb_write(3'd3, 8'h87);
    wb_read(3'd3, 8'h00);

    // Withdrawal by EN=0
    wb_write(3'd0, 8'h81);
    exp_q.push_back(3'd3);
    IRQ_IN = 8'h08;
    wait_req(20);
    wb_write(3'd0, 8'h00);
    tick();
    chk("withdraw_req", {7'b0, INT_REQo}, 8'h00);
    wb_read(3'd3, 8'h00);
    idle(10);

    // Ack and EN=0 write in the same cycle
    wb_write(3'd0, 8'h81);
    exp_q.push_back(3'd3);
    wait_req(20);
    INT_ACKi = 1'b1;
    wb_set_write(3'd0, 8'h00);
    tick();
    INT_ACKi = 1'b0;
    wb_clear();
    chk("ack_en_req", {7'b0, INT_REQo}, 8'h00);
    wb_read(3'd3, 8'h08);
    wb_read(3'd0, 8'h00);
    wb_write(3'd3, 8'h83);
    IRQ_IN = 8'h00;
    wb_read(3'd3, 8'h00);

    // Ack and EOI of the same bit: set wins
    wb_write(3'd0, 8'h81);
    exp_q.push_back(3'd5);
    IRQ_IN = 8'h20;
    wait_req(20);
    INT_ACKi = 1'b1;
    wb_set_write(3'd3, 8'h85);
    tick();
    INT_ACKi = 1'b0;
    wb_clear();
    wb_read(3'd3, 8'h20);

    // Reset during REQ
    exp_q.push_back(3'd6);
    IRQ_IN = 8'h60;
    wait_req(20);
    rst = 1'b1;
    tick();
    chk("rst_mid_req", {7'b0, INT_REQo}, 8'h00);
    rst = 1'b0;
    IRQ_IN = 8'h00;
    wb_read(3'd0, 8'h00);
    wb_read(3'd1, 8'h00);
    wb_read(3'd3, 8'h00);
    wb_read(3'd4, 8'h00);

    // Gap length between back-to-back requests
    wb_write(3'd1, 8'hFF);
    wb_write(3'd0, 8'h81);
    exp_q.push_back(3'd6);
    exp_q.push_back(3'd4);
    IRQ_IN = 8'h50;
    wait_req(20);
    ack();
    IRQ_IN = 8'h10;
    wb_set_write(3'd3, 8'h86);
    low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (INT_REQo) break;
      low_cnt++;
      tick();
      if (i == 0) wb_clear();
    end
    wb_clear();
    chk("gap_low_cycles", 8'(low_cnt), 8'(GAP + 1));
    ack();
    IRQ_IN = 8'h00;
    wb_write(3'd3, 8'h84);
    wb_read(3'd3, 8'h00);
    idle(10);

    // Final report
    checks++;
    if (exp_q.size() != 0 || exp_rd_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained got req_left=%0d rd_left=%0d exp=0", exp_q.size(), exp_rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
